// File: rtl/dmem_bytelane.sv
// dmem_bytelane: byte-addressable data memory for the single-cycle RV32I core.
//
// Purpose:
//   Little-endian byte storage with RV32I sub-word loads/stores (LB/LH/LW/LBU/LHU,
//   SB/SH/SW), misalignment / illegal-funct3 detection with a sticky error flag,
//   and an independent start/stop engine that walks the first DUMP_WORDS words.
//
// Parameters:
//   ADDR_W      byte-address bits used (memory is 2^ADDR_W bytes)
//   DUMP_WORDS  number of 32-bit words walked by the dump engine (1..2^(ADDR_W-2))
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   MemWrite, MemRead     store / load enables
//   funct3                RV32I access size/sign encoding
//   adress, Write_data    byte address (high bits alias), LSB-aligned store data
//   Read_data             combinational load result (0 when idle or faulting)
//   access_err            combinational: current access is misaligned or illegal
//   err_sticky            registered latch of any faulting access (reset-only clear)
//   dump_start            level request to run the dump
//   dump_valid/addr/data  current dumped word (addr/data forced to 0 when not valid)
//   dump_done             last word presented; held while dump_start stays high
//
// Handshake: dump_start is a level; the engine runs while it is high and returns
// to idle (counter cleared) on the first edge that samples it low.
//
// Memory contents start at zero; the synthesizable logic does not depend on it.
module dmem_bytelane #(
   parameter int ADDR_W     = 7,
   parameter int DUMP_WORDS = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              MemWrite,
   input  logic              MemRead,
   input  logic [2:0]        funct3,
   input  logic [31:0]       adress,
   input  logic [31:0]       Write_data,
   output logic [31:0]       Read_data,
   output logic              access_err,
   output logic              err_sticky,
   input  logic              dump_start,
   output logic              dump_valid,
   output logic [ADDR_W-1:0] dump_addr,
   output logic [31:0]       dump_data,
   output logic              dump_done
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int CW    = ADDR_W - 2;

   logic [7:0] mem [0:DEPTH-1];

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
   end

   // ---------------------------------------------------------------
   // Access decode
   // ---------------------------------------------------------------
   logic [ADDR_W-1:0] a0, a1, a2, a3;
   logic [1:0]        size;
   logic              ld_illegal, st_illegal, misaligned, illegal;

   assign a0   = adress[ADDR_W-1:0];
   assign a1   = a0 + ADDR_W'(1);
   assign a2   = a0 + ADDR_W'(2);
   assign a3   = a0 + ADDR_W'(3);
   assign size = funct3[1:0];

   // Loads accept 000/001/010/100/101; stores ignore signedness so any funct3[2]=1 is illegal.
   assign ld_illegal = (size == 2'b11) | (funct3[2] & funct3[1]);
   assign st_illegal = (size == 2'b11) | funct3[2];
   assign misaligned = ((size == 2'b01) & a0[0]) | ((size == 2'b10) & (a0[1:0] != 2'b00));
   assign illegal    = (MemRead & ld_illegal) | (MemWrite & st_illegal);
   assign access_err = (MemRead | MemWrite) & (misaligned | illegal);

   // ---------------------------------------------------------------
   // Load path (combinational, sees pre-edge contents)
   // ---------------------------------------------------------------
   logic [7:0] b0, b1, b2, b3;
   assign b0 = mem[a0];
   assign b1 = mem[a1];
   assign b2 = mem[a2];
   assign b3 = mem[a3];

   always_comb begin
      Read_data = 32'h0;
      if (MemRead && !access_err) begin
         case (funct3)
            3'b000:  Read_data = {{24{b0[7]}}, b0};
            3'b001:  Read_data = {{16{b1[7]}}, b1, b0};
            3'b010:  Read_data = {b3, b2, b1, b0};
            3'b100:  Read_data = {24'h0, b0};
            3'b101:  Read_data = {16'h0, b1, b0};
            default: Read_data = 32'h0;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Store path (memory is not reset)
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (MemWrite && !access_err) begin
         mem[a0] <= Write_data[7:0];
         if (size != 2'b00) mem[a1] <= Write_data[15:8];
         if (size == 2'b10) begin
            mem[a2] <= Write_data[23:16];
            mem[a3] <= Write_data[31:24];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          err_sticky <= 1'b0;
      else if (access_err) err_sticky <= 1'b1;
   end

   // ---------------------------------------------------------------
   // Dump engine
   // ---------------------------------------------------------------
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} dump_state_t;

   dump_state_t   dump_state, dump_state_nx;
   logic [CW-1:0] counter, counter_nx;
   logic          last_word;
   logic [ADDR_W-1:0] da0, da1, da2, da3;

   assign last_word = (counter == CW'(DUMP_WORDS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dump_state <= S_IDLE;
         counter    <= '0;
      end else begin
         dump_state <= dump_state_nx;
         counter    <= counter_nx;
      end
   end

   // dump_done is raised together with the last word while still in RUN,
   // then held by DONE, which keeps presenting that same word.
   always_comb begin
      dump_state_nx = dump_state;
      counter_nx    = counter;
      dump_valid    = 1'b0;
      dump_done     = 1'b0;
      case (dump_state)
         S_IDLE: begin
            counter_nx = '0;
            if (dump_start) dump_state_nx = S_RUN;
         end
         S_RUN: begin
            dump_valid = 1'b1;
            dump_done  = last_word;
            if (!dump_start) begin
               dump_state_nx = S_IDLE;
               counter_nx    = '0;
            end else if (last_word) begin
               dump_state_nx = S_DONE;
            end else begin
               counter_nx = counter + CW'(1);
            end
         end
         S_DONE: begin
            dump_valid = 1'b1;
            dump_done  = 1'b1;
            if (!dump_start) begin
               dump_state_nx = S_IDLE;
               counter_nx    = '0;
            end
         end
         default: begin
            dump_state_nx = S_IDLE;
            counter_nx    = '0;
         end
      endcase
   end

   assign dump_addr = dump_valid ? {counter, 2'b00} : '0;
   assign da0 = dump_addr;
   assign da1 = dump_addr + ADDR_W'(1);
   assign da2 = dump_addr + ADDR_W'(2);
   assign da3 = dump_addr + ADDR_W'(3);
   assign dump_data = dump_valid ? {mem[da3], mem[da2], mem[da1], mem[da0]} : 32'h0;

endmodule

// File: tb/tb_dmem_bytelane.sv
module tb_dmem_bytelane;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        MemWrite = 1'b0;
   logic        MemRead = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] adress = 32'h0;
   logic [31:0] Write_data = 32'h0;
   logic [31:0] Read_data;
   logic        access_err;
   logic        err_sticky;
   logic        dump_start = 1'b0;
   logic        dump_valid;
   logic [6:0]  dump_addr;
   logic [31:0] dump_data;
   logic        dump_done;

   int n_cmp = 0;
   int n_err = 0;

   dmem_bytelane #(.ADDR_W(7), .DUMP_WORDS(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .MemWrite   (MemWrite),
      .MemRead    (MemRead),
      .funct3     (funct3),
      .adress     (adress),
      .Write_data (Write_data),
      .Read_data  (Read_data),
      .access_err (access_err),
      .err_sticky (err_sticky),
      .dump_start (dump_start),
      .dump_valid (dump_valid),
      .dump_addr  (dump_addr),
      .dump_data  (dump_data),
      .dump_done  (dump_done)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
      MemWrite   = 1'b1;
      funct3     = f3;
      adress     = addr;
      Write_data = data;
      step();
      MemWrite   = 1'b0;
   endtask

   task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] exp);
      MemRead = 1'b1;
      funct3  = f3;
      adress  = addr;
      #1;
      check(tag, Read_data, exp);
      check({tag, "_err"}, {31'h0, access_err}, 32'h0);
      MemRead = 1'b0;
   endtask

   task automatic dump_chk(input string tag, input logic v, input logic [6:0] a,
                           input logic [31:0] d, input logic dn);
      check({tag, "_valid"}, {31'h0, dump_valid}, {31'h0, v});
      check({tag, "_addr"},  {25'h0, dump_addr},  {25'h0, a});
      check({tag, "_data"},  dump_data, d);
      check({tag, "_done"},  {31'h0, dump_done},  {31'h0, dn});
   endtask

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_sticky", {31'h0, err_sticky}, 32'h0);
      dump_chk("rst", 1'b0, 7'd0, 32'h0, 1'b0);
      rst_n = 1'b1;
      step();

      // word store and sub-word loads
      store(3'b010, 32'h10, 32'h8899AABB);
      load_chk("lw_10",  3'b010, 32'h10, 32'h8899AABB);
      load_chk("lb_13",  3'b000, 32'h13, 32'hFFFFFF88);
      load_chk("lbu_13", 3'b100, 32'h13, 32'h00000088);
      load_chk("lh_12",  3'b001, 32'h12, 32'hFFFF8899);
      load_chk("lhu_10", 3'b101, 32'h10, 32'h0000AABB);
      load_chk("lw_alias", 3'b010, 32'hFFFFFF90, 32'h8899AABB);

      // sub-word stores
      store(3'b000, 32'h11, 32'hFFFFFF5A);
      load_chk("sb_lw", 3'b010, 32'h10, 32'h88995ABB);
      store(3'b001, 32'h12, 32'hFFFF1234);
      load_chk("sh_lw", 3'b010, 32'h10, 32'h12345ABB);

      // same-cycle load/store at one address returns pre-edge data
      MemWrite = 1'b1; MemRead = 1'b1; funct3 = 3'b010; adress = 32'h10; Write_data = 32'h11112222;
      #1;
      check("rmw_old", Read_data, 32'h12345ABB);
      step();
      MemWrite = 1'b0; MemRead = 1'b0;
      load_chk("rmw_new", 3'b010, 32'h10, 32'h11112222);

      // misaligned word store
      store(3'b010, 32'h04, 32'h00000000);
      MemWrite = 1'b1; MemRead = 1'b1; funct3 = 3'b010; adress = 32'h06; Write_data = 32'hCAFEF00D;
      #1;
      check("mis_err", {31'h0, access_err}, 32'h1);
      check("mis_rd", Read_data, 32'h0);
      check("mis_sticky_pre", {31'h0, err_sticky}, 32'h0);
      step();
      MemWrite = 1'b0; MemRead = 1'b0;
      check("mis_sticky", {31'h0, err_sticky}, 32'h1);
      load_chk("mis_mem", 3'b010, 32'h04, 32'h0);
      load_chk("mis_mem_h", 3'b101, 32'h06, 32'h0);
      step();
      check("sticky_hold", {31'h0, err_sticky}, 32'h1);

      // misaligned half and illegal funct3 codes
      MemRead = 1'b1; funct3 = 3'b001; adress = 32'h11;
      #1;
      check("lh_mis_err", {31'h0, access_err}, 32'h1);
      funct3 = 3'b011; adress = 32'h10;
      #1;
      check("f3_011_err", {31'h0, access_err}, 32'h1);
      check("f3_011_rd", Read_data, 32'h0);
      MemRead = 1'b0; MemWrite = 1'b1; funct3 = 3'b100; adress = 32'h10; Write_data = 32'h0;
      #1;
      check("sbu_err", {31'h0, access_err}, 32'h1);
      step();
      MemWrite = 1'b0;
      load_chk("sbu_mem", 3'b010, 32'h10, 32'h11112222);

      // reset clears the sticky flag
      rst_n = 1'b0;
      #1;
      check("sticky_clr", {31'h0, err_sticky}, 32'h0);
      rst_n = 1'b1;
      step();

      // preload words 0..7 and run a full dump
      for (int k = 0; k < 8; k++) store(3'b010, 32'(k * 4), 32'(k));
      dump_start = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         dump_chk($sformatf("dump%0d", k), 1'b1, 7'(k * 4), 32'(k), (k == 7));
      end
      step();
      dump_chk("dump_hold1", 1'b1, 7'd28, 32'd7, 1'b1);
      step();
      dump_chk("dump_hold2", 1'b1, 7'd28, 32'd7, 1'b1);
      dump_start = 1'b0;
      step();
      dump_chk("dump_idle", 1'b0, 7'd0, 32'h0, 1'b0);

      // abort at addr 8, restart from 0
      dump_start = 1'b1;
      repeat (3) step();
      dump_chk("abort_at8", 1'b1, 7'd8, 32'd2, 1'b0);
      dump_start = 1'b0;
      step();
      dump_chk("abort_idle", 1'b0, 7'd0, 32'h0, 1'b0);
      dump_start = 1'b1;
      step();
      dump_chk("restart0", 1'b1, 7'd0, 32'd0, 1'b0);
      step();
      dump_chk("restart1", 1'b1, 7'd4, 32'd1, 1'b0);

      // asynchronous reset mid-dump
      #2;
      rst_n = 1'b0;
      #1;
      dump_chk("async_rst", 1'b0, 7'd0, 32'h0, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      dump_chk("post_rst", 1'b1, 7'd0, 32'd0, 1'b0);

      // same-cycle store while the dump presents the stored word
      MemWrite = 1'b1; funct3 = 3'b010; adress = 32'h00; Write_data = 32'hDEADBEEF;
      #1;
      check("same_cyc_dump", dump_data, 32'h0);
      step();
      MemWrite = 1'b0;
      dump_start = 1'b0;
      step();
      dump_start = 1'b1;
      step();
      dump_chk("new_dump", 1'b1, 7'd0, 32'hDEADBEEF, 1'b0);
      dump_start = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
